// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM-backed data memory controller.
package sram_controller_pkg;

  localparam int WORD_LEN          = 32;
  localparam int SRAM_ADDR_LEN     = 18;
  localparam int SRAM_DATA_LEN     = 16;
  localparam int DEF_BASE_ADDR     = 1024;
  localparam int DEF_ACCESS_CYCLES = 2;

  // Access sequence: each 32-bit word is split into a LO then a HI half access.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Byte address -> SRAM half-word address. Offsets outside the SRAM simply
  // wrap in the 17-bit word index; there is no range error.
  function automatic logic [SRAM_ADDR_LEN-1:0] half_addr(
    input logic [WORD_LEN-1:0] address,
    input logic [WORD_LEN-1:0] base,
    input logic                hi
  );
    logic [WORD_LEN-1:0] w_off;
    w_off = address - base;
    return {w_off[18:2], hi};
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Bundle of the pipeline request bus and the external SRAM pins.
//
// Handshake: rd_en/wr_en are level requests held by the frozen pipeline.
// ready=1 means "no request, or the current access has finished this cycle";
// ready=0 means the pipeline must freeze. A request is accepted only while the
// controller is idle, and an accepted access always runs to completion.
interface sram_controller_if;
  import sram_controller_pkg::*;

  logic                     rd_en;
  logic                     wr_en;
  logic [WORD_LEN-1:0]      address;
  logic [WORD_LEN-1:0]      write_data;
  logic [WORD_LEN-1:0]      read_data;
  logic                     ready;

  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic                     sram_we_n;
  logic                     sram_oe_n;
  logic                     sram_ce_n;
  logic                     sram_ub_n;
  logic                     sram_lb_n;

  // Pipeline / SRAM side (requester and memory device).
  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

  // Controller side.
  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
           sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_controller.sv
// Word load/store responder for the MEM stage: each 32-bit access becomes two
// 16-bit accesses (LO then HI) on an asynchronous SRAM. All SRAM pins are
// registered; ready is combinational so a new request freezes the pipeline
// in the cycle it appears.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR     = DEF_BASE_ADDR,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic   clk,
  input  logic   rst,
  sram_controller_if.slave bus,
  output state_t o_dbg_state
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0]       LAST_CNT = CW'(ACCESS_CYCLES - 1);
  localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(BASE_ADDR);

  state_t                   r_state;
  logic [CW-1:0]            r_cnt;
  logic                     r_is_write;
  logic [WORD_LEN-1:0]      r_address;
  logic [WORD_LEN-1:0]      r_wdata;
  logic [SRAM_DATA_LEN-1:0] r_lo_buf;
  logic [WORD_LEN-1:0]      r_read_data;
  logic [SRAM_ADDR_LEN-1:0] r_sram_addr;
  logic [SRAM_DATA_LEN-1:0] r_dq_out;
  logic                     r_dq_oe;
  logic                     r_we_n;
  logic                     r_oe_n;

  logic                     w_req;
  logic [CW-1:0]            w_cnt_next;

  // The write strobe is dropped one cycle before the half access ends so that
  // address and data are held past the rising edge of we_n. With a single
  // cycle per half there is no room for that, so we_n stays low throughout.
  function automatic logic we_active(input logic [CW-1:0] c);
    return (ACCESS_CYCLES == 1) || (c != LAST_CNT);
  endfunction

  assign w_req      = bus.rd_en | bus.wr_en;
  assign w_cnt_next = r_cnt + 1'b1;

  // Sequence the LO/HI half accesses and drive the registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_lo_buf    <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_is_write  <= bus.wr_en;
            r_address   <= bus.address;
            r_wdata     <= bus.write_data;
            r_cnt       <= '0;
            r_state     <= S_LO;
            r_sram_addr <= half_addr(bus.address, BASE, 1'b0);
            if (bus.wr_en) begin
              r_dq_out <= bus.write_data[15:0];
              r_dq_oe  <= 1'b1;
              r_we_n   <= ~we_active('0);
              r_oe_n   <= 1'b1;
            end else begin
              r_dq_oe  <= 1'b0;
              r_we_n   <= 1'b1;
              r_oe_n   <= 1'b0;
            end
          end
        end
        S_LO: begin
          if (r_cnt == LAST_CNT) begin
            if (!r_is_write) r_lo_buf <= bus.sram_dq_in;
            r_cnt       <= '0;
            r_state     <= S_HI;
            r_sram_addr <= half_addr(r_address, BASE, 1'b1);
            if (r_is_write) begin
              r_dq_out <= r_wdata[31:16];
              r_we_n   <= ~we_active('0);
            end
          end else begin
            r_cnt <= w_cnt_next;
            if (r_is_write) r_we_n <= ~we_active(w_cnt_next);
          end
        end
        S_HI: begin
          if (r_cnt == LAST_CNT) begin
            if (!r_is_write) r_read_data <= {bus.sram_dq_in, r_lo_buf};
            r_cnt   <= '0;
            r_state <= S_DONE;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_next;
            if (r_is_write) r_we_n <= ~we_active(w_cnt_next);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready       = ~w_req | (r_state == S_DONE);
  assign bus.read_data   = r_read_data;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;
  assign bus.sram_oe_n   = r_oe_n;
  assign bus.sram_ce_n   = 1'b0;
  assign bus.sram_ub_n   = 1'b0;
  assign bus.sram_lb_n   = 1'b0;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 256K x 16 SRAM.
module tb_sram_controller;
  import sram_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus();
  state_t dbg_state;

  sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:262143];
  logic [17:0] exp_lo, exp_hi;
  int we_cnt, oe_cnt, touch_err, pin_err;

  assign bus.sram_dq_in = (!bus.sram_oe_n) ? mem[bus.sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!rst) begin
      if (!bus.sram_we_n) begin
        mem[bus.sram_addr] <= bus.sram_dq_out;
        we_cnt = we_cnt + 1;
        if (!bus.sram_dq_oe || !bus.sram_oe_n) pin_err = pin_err + 1;
      end
      if (!bus.sram_oe_n) begin
        oe_cnt = oe_cnt + 1;
        if (bus.sram_dq_oe) pin_err = pin_err + 1;
      end
      if ((!bus.sram_we_n || !bus.sram_oe_n) &&
          bus.sram_addr != exp_lo && bus.sram_addr != exp_hi)
        touch_err = touch_err + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. With b2b set, the request is raised during DONE and
  // first sampled in the following IDLE cycle, which is then cycle 0.
  task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit b2b, input string tag);
    int cyc;
    logic [31:0] off;
    off    = addr - 32'd1024;
    exp_lo = {off[18:2], 1'b0};
    exp_hi = {off[18:2], 1'b1};
    we_cnt = 0; oe_cnt = 0; touch_err = 0; pin_err = 0;
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = addr;
    bus.write_data = wdata;
    if (b2b) @(negedge clk);
    #1;
    chk({tag, " ready_cycle0"}, 32'(bus.ready), 32'd0);
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, cyc, 32'd5);
  endtask

  task automatic finish_op(input string tag);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    chk({tag, " idle_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, " idle_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic chk_pins(input logic wr, input logic [31:0] wdata, input string tag);
    chk({tag, " we_cycles"}, we_cnt, wr ? 32'd2 : 32'd0);
    chk({tag, " oe_cycles"}, oe_cnt, wr ? 32'd0 : 32'd4);
    chk({tag, " foreign_addr"}, touch_err, 32'd0);
    chk({tag, " pin_conflict"}, pin_err, 32'd0);
    if (wr) begin
      chk({tag, " mem_lo"}, 32'(mem[exp_lo]), 32'(wdata[15:0]));
      chk({tag, " mem_hi"}, 32'(mem[exp_hi]), 32'(wdata[31:16]));
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 262144; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    we_cnt = 0; oe_cnt = 0; touch_err = 0; pin_err = 0;
    exp_lo = '0; exp_hi = '0;

    vecs[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 32'd1032, 32'hA5A50F0F, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hA5A50F0F};
    vecs[4] = '{1'b1, 1'b0, 32'd1424, 32'h0,        32'h5A935A92};
    vecs[5] = '{1'b0, 1'b1, 32'd1020, 32'h11223344, 32'h5A935A92};
    vecs[6] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'h11223344};
    vecs[7] = '{1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 32'h11223344};
    vecs[8] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'hCAFEF00D};

    // Reset held for 3 cycles.
    rst = 1'b1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.address = '0; bus.write_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst read_data", bus.read_data, 32'd0);
    chk("rst ready", 32'(bus.ready), 32'd1);
    chk("rst pins", {26'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe,
                     bus.sram_ce_n, bus.sram_ub_n, bus.sram_lb_n}, 32'b110000);
    chk("rst sram_addr", 32'(bus.sram_addr), 32'd0);
    chk("rst state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);

    // Table-driven single accesses.
    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      exp_q.push_back(vecs[i].exp_rdata);
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, tag);
      got = bus.read_data;
      chk({tag, " read_data"}, got, exp_q.pop_front());
      chk_pins(vecs[i].wr, vecs[i].wdata, tag);
      finish_op(tag);
    end

    // Back-to-back: store then load with one IDLE cycle between.
    run_op(1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, "b2b_st");
    chk_pins(1'b1, 32'h12345678, "b2b_st");
    run_op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, "b2b_ld");
    chk("b2b_ld read_data", bus.read_data, 32'h12345678);
    chk_pins(1'b0, 32'h0, "b2b_ld");
    finish_op("b2b_ld");

    // Reset in cycle 2 of a load.
    bus.rd_en = 1'b1; bus.wr_en = 1'b0; bus.address = 32'd1028;
    exp_lo = 18'd2; exp_hi = 18'd3;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst read_data", bus.read_data, 32'd0);
    chk("midrst pins", {29'd0, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}, 32'b110);
    chk("midrst state", 32'(dbg_state), 32'(S_IDLE));
    chk("midrst ready", 32'(bus.ready), 32'd1);
    @(negedge clk);
    run_op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, "postrst");
    chk("postrst read_data", bus.read_data, 32'hDEADBEEF);
    chk_pins(1'b0, 32'h0, "postrst");
    finish_op("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
